// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS timer sequencer.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PAUSE   = 3'd2,
    SET_MIN = 3'd3,
    SET_SEC = 3'd4,
    ALARM   = 3'd5
  } timer_state_t;

  localparam logic [1:0]  TIMER_LOCKOUT = 2'd2;
  localparam logic [15:0] BCD_ZERO      = 16'h0000;

endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 while enabled, pulses tick on the wrap cycle.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/set/alarm sequencer driving step strobes into the MM:SS BCD counter bank.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int BLINK_DIV   = 4,
  parameter int ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_stop,
  input  logic        set_btn,
  input  logic        up_btn,
  input  logic        down_btn,
  input  logic        mode_down,
  input  logic [15:0] digits_in,
  output logic        sec_step,
  output logic        min_step,
  output logic        step_dec,
  output logic        counter_clr,
  output logic        alarm,
  output logic        blink,
  output logic [2:0]  state_o
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int AW  = $clog2(ALARM_TICKS + 1);
  localparam int BW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  timer_state_t  state, state_nx;
  logic          dir_down, dir_nx;
  logic [1:0]    lock_q, lock_nx;
  logic          defer_q, defer_nx;
  logic [AW-1:0] alarm_cnt, alarm_cnt_nx;
  logic          sec_nx, min_nx, dec_nx, clr_nx;
  logic          locked, in_set, tick, tg_en, tg_clr;
  logic          blink_q;
  logic [BW-1:0] blink_cnt;

  assign locked  = (lock_q != 2'd0);
  assign in_set  = (state == SET_MIN) || (state == SET_SEC);
  // Prescaler freezes in PAUSE and on the pause edge itself, so resume continues mid-second.
  assign tg_en   = ((state == RUN) && !start_stop) || in_set || (state == ALARM);
  assign tg_clr  = (state == IDLE);
  assign state_o = state;
  assign blink   = blink_q & in_set;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (tg_en),
    .clr     (tg_clr),
    .tick    (tick)
  );

  always_comb begin
    state_nx     = state;
    dir_nx       = dir_down;
    lock_nx      = locked ? lock_q - 2'd1 : 2'd0;
    defer_nx     = defer_q;
    alarm_cnt_nx = '0;
    sec_nx       = 1'b0;
    min_nx       = 1'b0;
    dec_nx       = 1'b0;
    clr_nx       = 1'b0;
    case (state)
      IDLE: begin
        defer_nx = 1'b0;
        if (start_stop) begin
          state_nx = RUN;
          dir_nx   = mode_down;
        end else if (set_btn) begin
          state_nx = SET_MIN;
        end
      end
      RUN: begin
        if (start_stop) begin
          state_nx = PAUSE;
        end else if (tick || defer_q) begin
          // A wrap landing inside the bank's carry window is held until the window closes.
          if (locked) begin
            defer_nx = 1'b1;
          end else begin
            defer_nx = 1'b0;
            if (dir_down && (digits_in == BCD_ZERO)) begin
              state_nx = ALARM;
            end else begin
              sec_nx  = 1'b1;
              dec_nx  = dir_down;
              lock_nx = TIMER_LOCKOUT;
            end
          end
        end
      end
      PAUSE: begin
        if (start_stop) begin
          state_nx = RUN;
        end else if (set_btn) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
        end
      end
      SET_MIN: begin
        if (start_stop) begin
          state_nx = IDLE;
        end else if (set_btn) begin
          state_nx = SET_SEC;
        end else if ((up_btn || down_btn) && !locked) begin
          min_nx  = 1'b1;
          dec_nx  = !up_btn;
          lock_nx = TIMER_LOCKOUT;
        end
      end
      SET_SEC: begin
        if (start_stop || set_btn) begin
          state_nx = IDLE;
        end else if ((up_btn || down_btn) && !locked) begin
          sec_nx  = 1'b1;
          dec_nx  = !up_btn;
          lock_nx = TIMER_LOCKOUT;
        end
      end
      ALARM: begin
        alarm_cnt_nx = alarm_cnt;
        if (start_stop) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
        end else if (tick) begin
          if (alarm_cnt == ALARM_LAST) begin
            state_nx = IDLE;
            clr_nx   = 1'b1;
          end else begin
            alarm_cnt_nx = alarm_cnt + 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dir_down    <= 1'b0;
      lock_q      <= 2'd0;
      defer_q     <= 1'b0;
      alarm_cnt   <= '0;
      sec_step    <= 1'b0;
      min_step    <= 1'b0;
      step_dec    <= 1'b0;
      counter_clr <= 1'b0;
      alarm       <= 1'b0;
    end else begin
      state       <= state_nx;
      dir_down    <= dir_nx;
      lock_q      <= lock_nx;
      defer_q     <= defer_nx;
      alarm_cnt   <= alarm_cnt_nx;
      sec_step    <= sec_nx;
      min_step    <= min_nx;
      step_dec    <= dec_nx;
      counter_clr <= clr_nx;
      alarm       <= (state_nx == ALARM);
    end
  end

  // Blink phase restarts from "shown" each time a set field is entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (!in_set) begin
      blink_q   <= 1'b0;
      blink_cnt <= '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with a behavioural MM:SS counter-bank model attached.
module tb_timer_ctrl;
  import timer_pkg::*;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_stop = 1'b0, set_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
  logic        mode_down = 1'b0;
  logic [15:0] digits_in;
  logic        sec_step, min_step, step_dec, counter_clr, alarm, blink;
  logic [2:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  int   bank_s = 0;
  logic load_en = 1'b0;
  int   load_val = 0;

  timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .BLINK_DIV(2), .ALARM_TICKS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start_stop(start_stop), .set_btn(set_btn),
    .up_btn(up_btn), .down_btn(down_btn), .mode_down(mode_down), .digits_in(digits_in),
    .sec_step(sec_step), .min_step(min_step), .step_dec(step_dec),
    .counter_clr(counter_clr), .alarm(alarm), .blink(blink), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  assign digits_in = bcd(bank_s);

  // Counter bank: whole-value seconds stepping, minutes-only stepping, clear.
  always @(posedge clk) begin
    if (load_en) bank_s <= load_val;
    else if (counter_clr) bank_s <= 0;
    else if (sec_step) bank_s <= step_dec ? (bank_s + 3599) % 3600 : (bank_s + 1) % 3600;
    else if (min_step)
      bank_s <= (step_dec ? ((bank_s / 60 + 59) % 60) : ((bank_s / 60 + 1) % 60)) * 60 + bank_s % 60;
  end

  task automatic step(input logic ss, input logic sb, input logic ub, input logic db);
    start_stop = ss; set_btn = sb; up_btn = ub; down_btn = db;
    @(posedge clk); #1;
    start_stop = 1'b0; set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
  endtask

  task automatic cyc();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int bank_val);
    reset_n = 1'b0; load_en = 1'b1; load_val = bank_val; mode_down = 1'b0;
    start_stop = 1'b0; set_btn = 1'b0; up_btn = 1'b0; down_btn = 1'b0;
    @(posedge clk); #1;
    load_en = 1'b0; reset_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc();
    reset_n = 1'b0; #1;
    n_cmp++; if (state_o !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", state_o, IDLE); end
    n_cmp++; if ({sec_step, min_step, step_dec, counter_clr, alarm, blink} !== 6'b0) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 000000", {sec_step, min_step, step_dec, counter_clr, alarm, blink}); end
    @(posedge clk); #1; reset_n = 1'b1;
    cyc();
    n_cmp++; if (state_o !== IDLE) begin n_err++; $display("FAIL reset_release_state: got %0d expected %0d", state_o, IDLE); end
  endtask

  task automatic test_count_up();
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 25; c++) begin
      cyc();
      n_cmp++; if (sec_step !== (c % DIV == 0)) begin n_err++; $display("FAIL up_sec_step c=%0d: got %b expected %b", c, sec_step, (c % DIV == 0)); end
      if (c % DIV == 0) begin
        n_cmp++; if (step_dec !== 1'b0) begin n_err++; $display("FAIL up_step_dec c=%0d: got %b expected 0", c, step_dec); end
      end
    end
    n_cmp++; if (digits_in !== 16'h0002) begin n_err++; $display("FAIL up_bank: got %h expected 0002", digits_in); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state_o !== PAUSE) begin n_err++; $display("FAIL up_pause: got %0d expected %0d", state_o, PAUSE); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({counter_clr, state_o} !== {1'b1, 3'(IDLE)}) begin n_err++; $display("FAIL pause_clear: got clr=%b st=%0d expected clr=1 st=%0d", counter_clr, state_o, IDLE); end
    cyc();
    n_cmp++; if (bank_s !== 0) begin n_err++; $display("FAIL pause_clear_bank: got %0d expected 0", bank_s); end
  endtask

  task automatic test_countdown();
    int alarm_at, clr_at;
    logic step_at_alarm;
    do_reset(60);
    mode_down = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    alarm_at = -1; clr_at = -1; step_at_alarm = 1'b1;
    for (int c = 1; c <= 700 && alarm_at < 0; c++) begin
      cyc();
      if (alarm) begin alarm_at = c; step_at_alarm = sec_step; end
      else begin
        n_cmp++; if (sec_step !== (c % DIV == 0)) begin n_err++; $display("FAIL down_sec_step c=%0d: got %b expected %b", c, sec_step, (c % DIV == 0)); end
        if (sec_step && step_dec !== 1'b1) begin n_cmp++; n_err++; $display("FAIL down_step_dec c=%0d: got 0 expected 1", c); end
      end
    end
    n_cmp++; if (alarm_at !== 610) begin n_err++; $display("FAIL alarm_cycle: got %0d expected 610", alarm_at); end
    n_cmp++; if (step_at_alarm !== 1'b0) begin n_err++; $display("FAIL alarm_no_step: got %b expected 0", step_at_alarm); end
    n_cmp++; if (bank_s !== 0) begin n_err++; $display("FAIL down_bank_zero: got %0d expected 0", bank_s); end
    for (int c = alarm_at + 1; c <= 700 && clr_at < 0 && alarm_at > 0; c++) begin
      cyc();
      if (counter_clr) begin
        clr_at = c;
        n_cmp++; if ({alarm, state_o} !== {1'b0, 3'(IDLE)}) begin n_err++; $display("FAIL alarm_exit: got alarm=%b st=%0d expected alarm=0 st=%0d", alarm, state_o, IDLE); end
      end
    end
    n_cmp++; if (clr_at !== 640) begin n_err++; $display("FAIL alarm_timeout_cycle: got %0d expected 640", clr_at); end
  endtask

  task automatic test_alarm_ack();
    do_reset(1);
    mode_down = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      cyc();
      n_cmp++; if (alarm !== (c >= 20)) begin n_err++; $display("FAIL ack_alarm c=%0d: got %b expected %b", c, alarm, (c >= 20)); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({counter_clr, alarm, state_o} !== {2'b10, 3'(IDLE)}) begin
      n_err++; $display("FAIL ack_exit: got clr=%b alarm=%b st=%0d expected clr=1 alarm=0 st=%0d", counter_clr, alarm, state_o, IDLE); end
  endtask

  task automatic test_pause();
    int seen;
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) cyc();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (state_o !== PAUSE) begin n_err++; $display("FAIL pause_enter: got %0d expected %0d", state_o, PAUSE); end
    seen = 0;
    repeat (40) begin cyc(); if (sec_step || state_o !== PAUSE) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL pause_hold: got %0d bad cycles expected 0", seen); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      n_cmp++; if (sec_step !== (c == 3)) begin n_err++; $display("FAIL resume_step c=%0d: got %b expected %b", c, sec_step, (c == 3)); end
    end
  endtask

  task automatic test_set();
    do_reset(0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== SET_MIN) begin n_err++; $display("FAIL set_min_enter: got %0d expected %0d", state_o, SET_MIN); end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if ({min_step, step_dec} !== {(k == 0), 1'b0}) begin
        n_err++; $display("FAIL set_lockout k=%0d: got min=%b dec=%b expected min=%b dec=0", k, min_step, step_dec, (k == 0)); end
    end
    cyc();
    n_cmp++; if (digits_in !== 16'h0100) begin n_err++; $display("FAIL set_min_bank: got %h expected 0100", digits_in); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== SET_SEC) begin n_err++; $display("FAIL set_sec_enter: got %0d expected %0d", state_o, SET_SEC); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if ({sec_step, step_dec, min_step} !== 3'b110) begin n_err++; $display("FAIL set_sec_down: got %b expected 110", {sec_step, step_dec, min_step}); end
    cyc();
    n_cmp++; if (digits_in !== 16'h0059) begin n_err++; $display("FAIL set_sec_bank: got %h expected 0059", digits_in); end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== IDLE) begin n_err++; $display("FAIL set_sec_exit: got %0d expected %0d", state_o, IDLE); end
  endtask

  task automatic test_blink();
    do_reset(0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      cyc();
      n_cmp++; if (blink !== ((c / 20) % 2 == 1)) begin n_err++; $display("FAIL blink c=%0d: got %b expected %b", c, blink, ((c / 20) % 2 == 1)); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if ({blink, state_o} !== {1'b0, 3'(IDLE)}) begin n_err++; $display("FAIL blink_exit: got blink=%b st=%0d expected 0/%0d", blink, state_o, IDLE); end
  endtask

  task automatic test_same_cycle();
    do_reset(0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (state_o !== RUN) begin n_err++; $display("FAIL priority_run: got %0d expected %0d", state_o, RUN); end
    cyc();
    n_cmp++; if (state_o !== RUN) begin n_err++; $display("FAIL priority_hold: got %0d expected %0d", state_o, RUN); end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    do_reset(0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc();
    n_cmp++; if (sec_step !== 1'b1) begin n_err++; $display("FAIL midrun_pre_step: got %b expected 1", sec_step); end
    #2 reset_n = 1'b0; #1;
    n_cmp++; if ({state_o, sec_step, step_dec} !== {3'(IDLE), 2'b00}) begin
      n_err++; $display("FAIL midrun_async: got st=%0d step=%b expected st=%0d step=0", state_o, sec_step, IDLE); end
    @(posedge clk); #1; reset_n = 1'b1;
    bad = 0;
    repeat (10) begin cyc(); if (sec_step || state_o !== IDLE) bad++; end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL midrun_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_random_run();
    int b0, p, steps;
    logic running, ss, exp;
    b0 = $urandom_range(0, 3599);
    do_reset(b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    running = 1'b1; p = 0; steps = 0;
    for (int c = 0; c < 300; c++) begin
      ss = ($urandom_range(0, 15) == 0) || (c == 299 && running);
      exp = 1'b0;
      if (running) begin
        if (ss) running = 1'b0;
        else begin
          p++;
          if (p == DIV) begin p = 0; exp = 1'b1; steps++; end
        end
      end else if (ss) running = 1'b1;
      step(ss, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (sec_step !== exp) begin n_err++; $display("FAIL rand_run_step c=%0d: got %b expected %b", c, sec_step, exp); end
    end
    cyc();
    n_cmp++; if (bank_s !== (b0 + steps) % 3600) begin n_err++; $display("FAIL rand_run_bank: got %0d expected %0d", bank_s, (b0 + steps) % 3600); end
  endtask

  task automatic test_random_set();
    int b0, e, last, mm, sec, gap;
    logic dn, acc;
    b0 = $urandom_range(0, 3599);
    do_reset(b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    e = 0; last = -100; mm = b0 / 60; sec = b0 % 60;
    for (int k = 0; k < 40; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin cyc(); e++; end
      dn = 1'($urandom_range(0, 1));
      step(1'b0, 1'b0, !dn, dn); e++;
      acc = (e - last >= 3);
      if (acc) begin last = e; mm = dn ? (mm + 59) % 60 : (mm + 1) % 60; end
      n_cmp++; if (min_step !== acc) begin n_err++; $display("FAIL rand_set_step k=%0d: got %b expected %b", k, min_step, acc); end
      if (acc) begin
        n_cmp++; if (step_dec !== dn) begin n_err++; $display("FAIL rand_set_dec k=%0d: got %b expected %b", k, step_dec, dn); end
      end
    end
    cyc(); cyc();
    n_cmp++; if (bank_s !== mm * 60 + sec) begin n_err++; $display("FAIL rand_set_bank: got %0d expected %0d", bank_s, mm * 60 + sec); end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_countdown();
    test_alarm_ack();
    test_pause();
    test_set();
    test_blink();
    test_same_cycle();
    test_reset_mid_run();
    test_random_run();
    test_random_set();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
